// File: rtl/cim_pkg.sv
// Shared types and default geometry for the CIM activation path.
// Imported by the slice sequencer and its testbench.
package cim_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } slice_state_t;

  localparam int CIM_N_CH   = 36;
  localparam int CIM_DATA_W = 8;

endpackage

// File: rtl/cim_slice_mux.sv
// Per-channel slice select with zero LSB padding.
// Output is forced to zero when en is low.
module cim_slice_mux #(
  parameter int N_CH    = 36,
  parameter int DATA_W  = 8,
  parameter int SLICE_W = 2,
  parameter int PAD_W   = 1,
  parameter int IDX_W   = 2
) (
  input  logic                                en,
  input  logic [N_CH-1:0][DATA_W-1:0]         buf_i,
  input  logic [IDX_W-1:0]                    k,
  output logic [N_CH-1:0][SLICE_W+PAD_W-1:0]  slice_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SLICE_W-1:0] s;
    assign s = en ? buf_i[i][int'(k)*SLICE_W +: SLICE_W] : '0;
    if (PAD_W > 0) begin : g_pad
      assign slice_o[i] = {s, {PAD_W{1'b0}}};
    end else begin : g_nopad
      assign slice_o[i] = s;
    end
  end

endmodule

// File: rtl/cim_slice_sequencer.sv
// Holds one input vector and streams it out as bit slices,
// LSB- or MSB-first, with valid/ready on both sides.
module cim_slice_sequencer
  import cim_pkg::*;
#(
  parameter  int N_CH       = CIM_N_CH,
  parameter  int DATA_W     = CIM_DATA_W,
  parameter  int SLICE_W    = 2,
  parameter  int PAD_W      = 1,
  localparam int NUM_SLICES = DATA_W / SLICE_W,
  localparam int IDX_W      = (NUM_SLICES > 2) ? $clog2(NUM_SLICES) : 1,
  localparam int OUT_W      = SLICE_W + PAD_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_CH-1:0][DATA_W-1:0]   in_data,
  input  logic                          msb_first,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_CH-1:0][OUT_W-1:0]    out_slice,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic                          busy
);

  if ((DATA_W % SLICE_W) != 0 || NUM_SLICES < 2) begin : g_bad_cfg
    $error("cim_slice_sequencer: DATA_W must be a multiple of SLICE_W, >=2 slices");
  end

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_SLICES - 1);

  slice_state_t               state_q, state_d;
  logic [N_CH-1:0][DATA_W-1:0] buf_q, buf_d;
  logic                       order_q, order_d;
  logic [IDX_W-1:0]           beat_q, beat_d;

  logic             stream;
  logic             accept;
  logic [IDX_W-1:0] k;

  assign stream    = (state_q == STREAM);
  assign busy      = stream;
  assign out_valid = stream;
  assign out_last  = stream && (beat_q == LAST_BEAT);
  assign in_ready  = !stream || (out_last && out_ready);
  assign accept    = in_valid && in_ready;

  // Slice position; forced to 0 while idle
  always_comb begin
    k = '0;
    if (stream) k = order_q ? (LAST_BEAT - beat_q) : beat_q;
  end

  assign out_idx = k;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    order_d = order_q;
    beat_d  = beat_q;
    if (accept) begin
      state_d = STREAM;
      buf_d   = in_data;
      order_d = msb_first;
      beat_d  = '0;
    end else if (stream && out_ready) begin
      if (out_last) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      order_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      order_q <= order_d;
      beat_q  <= beat_d;
    end
  end

  cim_slice_mux #(
    .N_CH    (N_CH),
    .DATA_W  (DATA_W),
    .SLICE_W (SLICE_W),
    .PAD_W   (PAD_W),
    .IDX_W   (IDX_W)
  ) u_mux (
    .en      (stream),
    .buf_i   (buf_q),
    .k       (k),
    .slice_o (out_slice)
  );

endmodule

// File: tb/tb_cim_slice_sequencer.sv
// Directed vector bench for cim_slice_sequencer (default geometry
// plus a 4-channel, 4-bit-slice, unpadded variant).
module tb_cim_slice_sequencer;
  import cim_pkg::*;

  localparam int N = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid, in_ready, msb_first;
  logic [N-1:0][7:0] in_data;
  logic              out_valid, out_ready, out_last, busy;
  logic [N-1:0][2:0] out_slice;
  logic [1:0]        out_idx;

  cim_slice_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .msb_first (msb_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slice (out_slice),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  logic              v_in_valid, v_in_ready, v_msb_first;
  logic [3:0][7:0]   v_in_data;
  logic              v_out_valid, v_out_ready, v_out_last, v_busy;
  logic [3:0][3:0]   v_out_slice;
  logic [0:0]        v_out_idx;

  cim_slice_sequencer #(
    .N_CH    (4),
    .DATA_W  (8),
    .SLICE_W (4),
    .PAD_W   (0)
  ) dut_v (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v_in_valid),
    .in_ready  (v_in_ready),
    .in_data   (v_in_data),
    .msb_first (v_msb_first),
    .out_valid (v_out_valid),
    .out_ready (v_out_ready),
    .out_slice (v_out_slice),
    .out_idx   (v_out_idx),
    .out_last  (v_out_last),
    .busy      (v_busy)
  );

  typedef struct packed {
    logic       rst;
    logic       iv;
    logic       msb;
    logic [7:0] data;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [2:0] e_sl;
    logic [1:0] e_idx;
    logic       e_last;
    logic       e_busy;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic iv, input logic m,
                     input logic [7:0] d, input logic ordy,
                     input logic ir, input logic ov, input logic [2:0] sl,
                     input logic [1:0] idx, input logic last,
                     input logic bz);
    vec_t v;
    v = '{r, iv, m, d, ordy, ir, ov, sl, idx, last, bz};
    tv.push_back(v);
  endtask

  // Idle row (no input offered, consumer ready)
  task automatic idle_row();
    add(0, 0, 0, 8'h00, 1, 1, 0, 3'b000, 2'd0, 0, 0);
  endtask

  task automatic beat(input logic [7:0] d, input logic ordy,
                      input logic [2:0] sl, input logic [1:0] idx,
                      input logic last);
    add(0, 0, 0, d, ordy, last & ordy, 1, sl, idx, last, 1);
  endtask

  task automatic v_check(input string nm, input logic ov,
                         input logic [3:0] sl, input logic idx,
                         input logic last);
    logic [3:0][3:0] es;
    es = {4{sl}};
    n_vec++;
    if (v_out_valid !== ov || v_out_slice !== es ||
        v_out_idx !== idx || v_out_last !== last) begin
      n_bad++;
      $display("FAIL %s: got ov=%b sl=%h idx=%0d last=%b, want ov=%b sl=%h idx=%0d last=%b",
               nm, v_out_valid, v_out_slice, v_out_idx, v_out_last,
               ov, es, idx, last);
    end
  endtask

  initial begin
    logic [N-1:0][2:0] es;
    vec_t v;

    // LSB-first stream of E4
    idle_row();
    add(0, 1, 0, 8'hE4, 1, 1, 0, 3'b000, 2'd0, 0, 0);
    beat(8'hE4, 1, 3'b000, 2'd0, 0);
    beat(8'hE4, 1, 3'b010, 2'd1, 0);
    beat(8'hE4, 1, 3'b100, 2'd2, 0);
    beat(8'hE4, 1, 3'b110, 2'd3, 1);
    idle_row();
    // MSB-first
    add(0, 1, 1, 8'hE4, 1, 1, 0, 3'b000, 2'd0, 0, 0);
    beat(8'h00, 1, 3'b110, 2'd3, 0);
    beat(8'h00, 1, 3'b100, 2'd2, 0);
    beat(8'h00, 1, 3'b010, 2'd1, 0);
    beat(8'h00, 1, 3'b000, 2'd0, 1);
    idle_row();
    // Backpressure at beat 1, then on the last beat
    add(0, 1, 0, 8'hE4, 1, 1, 0, 3'b000, 2'd0, 0, 0);
    beat(8'h00, 1, 3'b000, 2'd0, 0);
    beat(8'h00, 0, 3'b010, 2'd1, 0);
    beat(8'h00, 0, 3'b010, 2'd1, 0);
    beat(8'h00, 0, 3'b010, 2'd1, 0);
    beat(8'h00, 1, 3'b010, 2'd1, 0);
    beat(8'h00, 1, 3'b100, 2'd2, 0);
    beat(8'h00, 0, 3'b110, 2'd3, 1);
    beat(8'h00, 1, 3'b110, 2'd3, 1);
    idle_row();
    // Back-to-back: 1B offered on the last beat; in_data churn ignored
    add(0, 1, 0, 8'hE4, 1, 1, 0, 3'b000, 2'd0, 0, 0);
    beat(8'h00, 1, 3'b000, 2'd0, 0);
    beat(8'h00, 1, 3'b010, 2'd1, 0);
    beat(8'h00, 1, 3'b100, 2'd2, 0);
    add(0, 1, 0, 8'h1B, 1, 1, 1, 3'b110, 2'd3, 1, 1);
    beat(8'hFF, 1, 3'b110, 2'd0, 0);
    beat(8'hFF, 1, 3'b100, 2'd1, 0);
    beat(8'hFF, 1, 3'b010, 2'd2, 0);
    beat(8'h00, 1, 3'b000, 2'd3, 1);
    idle_row();
    // Reset at beat 2 overrides in_valid/out_ready
    add(0, 1, 0, 8'hE4, 1, 1, 0, 3'b000, 2'd0, 0, 0);
    beat(8'h00, 1, 3'b000, 2'd0, 0);
    beat(8'h00, 1, 3'b010, 2'd1, 0);
    add(1, 1, 0, 8'h1B, 1, 0, 1, 3'b100, 2'd2, 0, 1);
    idle_row();
    add(0, 1, 0, 8'h1B, 1, 1, 0, 3'b000, 2'd0, 0, 0);
    beat(8'h00, 1, 3'b110, 2'd0, 0);
    beat(8'h00, 1, 3'b100, 2'd1, 0);
    beat(8'h00, 1, 3'b010, 2'd2, 0);
    beat(8'h00, 1, 3'b000, 2'd3, 1);
    idle_row();

    rst = 1'b1;
    in_valid = 1'b0; msb_first = 1'b0; out_ready = 1'b1; in_data = '0;
    v_in_valid = 1'b0; v_msb_first = 1'b0; v_out_ready = 1'b1;
    v_in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      v = tv[i];
      rst       = v.rst;
      in_valid  = v.iv;
      msb_first = v.msb;
      in_data   = {N{v.data}};
      out_ready = v.ordy;
      #1;
      es = {N{v.e_sl}};
      n_vec++;
      if (in_ready !== v.e_ir || out_valid !== v.e_ov ||
          out_slice !== es || out_idx !== v.e_idx ||
          out_last !== v.e_last || busy !== v.e_busy) begin
        n_bad++;
        $display("FAIL vec%0d: got ir=%b ov=%b sl0=%b idx=%0d last=%b busy=%b, want ir=%b ov=%b sl=%b(all ch) idx=%0d last=%b busy=%b",
                 i, in_ready, out_valid, out_slice[0], out_idx, out_last,
                 busy, v.e_ir, v.e_ov, v.e_sl, v.e_idx, v.e_last,
                 v.e_busy);
      end
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0;

    // Variant: 2 beats of 4 bits, no padding
    v_in_valid = 1'b1; v_in_data = {4{8'hA5}}; v_msb_first = 1'b0;
    #1;
    n_vec++;
    if (v_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL v_ready: got %b want 1", v_in_ready);
    end
    @(negedge clk);
    v_in_valid = 1'b0; v_in_data = '0;
    #1 v_check("v_lsb_b0", 1, 4'h5, 1'b0, 0);
    @(negedge clk);
    #1 v_check("v_lsb_b1", 1, 4'hA, 1'b1, 1);
    @(negedge clk);
    #1 v_check("v_idle", 0, 4'h0, 1'b0, 0);
    v_in_valid = 1'b1; v_in_data = {4{8'hA5}}; v_msb_first = 1'b1;
    @(negedge clk);
    v_in_valid = 1'b0; v_msb_first = 1'b0;
    #1 v_check("v_msb_b0", 1, 4'hA, 1'b1, 0);
    @(negedge clk);
    #1 v_check("v_msb_b1", 1, 4'h5, 1'b0, 1);
    @(negedge clk);
    #1 v_check("v_idle2", 0, 4'h0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
